// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: operand/opcode entry and ALU launch controller.
// Optional: define CALC_SEQ_TIMEOUT_EN to enable the WAIT watchdog.
module calc_op_sequencer #(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_strobe,
    input  logic               in_clear,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_op,
    output logic               alu_start,
    input  logic               alu_done,
    input  logic               alu_err,
    input  logic [2*WIDTH-1:0] alu_result,
    output logic [2*WIDTH-1:0] result,
    output logic               result_valid,
    output logic               err,
    output logic               busy,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GOT_A  = 3'd1,
        S_GOT_B  = 3'd2,
        S_LAUNCH = 3'd3,
        S_WAIT   = 3'd4,
        S_SHOW   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_t st;
    logic   s1;
    logic   s2;
    logic   s3;
    logic   ev;
    logic   op_divmod;
    logic   b_zero;

`ifdef CALC_SEQ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
`endif

    // Synchronize the push-button level and keep one delayed copy for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= in_strobe;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign ev        = s2 & ~s3 & ena;
    assign op_divmod = (in_data[2:0] == 3'd3) || (in_data[2:0] == 3'd4);
    assign b_zero    = (alu_b == '0);
    assign busy      = (st == S_LAUNCH) || (st == S_WAIT);
    assign state     = st;

    // Sequencer: operand capture, ALU handshake, result/error holding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= S_IDLE;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            alu_start    <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
`ifdef CALC_SEQ_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            alu_start <= 1'b0;
            if (in_clear) begin
                st           <= S_IDLE;
                alu_a        <= '0;
                alu_b        <= '0;
                alu_op       <= '0;
                result       <= '0;
                result_valid <= 1'b0;
                err          <= 1'b0;
`ifdef CALC_SEQ_TIMEOUT_EN
                wait_cnt     <= '0;
`endif
            end else begin
                unique case (st)
                    S_IDLE: begin
                        if (ev) begin
                            alu_a <= in_data;
                            st    <= S_GOT_A;
                        end
                    end
                    S_GOT_A: begin
                        if (ev) begin
                            alu_b <= in_data;
                            st    <= S_GOT_B;
                        end
                    end
                    S_GOT_B: begin
                        if (ev) begin
                            alu_op <= in_data[2:0];
                            if (op_divmod && b_zero) begin
                                err    <= 1'b1;
                                result <= '0;
                                st     <= S_ERR;
                            end else begin
                                alu_start <= 1'b1;
                                st        <= S_LAUNCH;
                            end
                        end
                    end
                    S_LAUNCH: begin
`ifdef CALC_SEQ_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        st <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (alu_done) begin
                            result       <= alu_result;
                            result_valid <= 1'b1;
                            err          <= alu_err;
                            st           <= alu_err ? S_ERR : S_SHOW;
`ifdef CALC_SEQ_TIMEOUT_EN
                        end else if (wait_cnt == TO_LAST) begin
                            err          <= 1'b1;
                            result       <= '1;
                            result_valid <= 1'b0;
                            st           <= S_ERR;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
`endif
                        end
                    end
                    S_SHOW: begin
                        if (ev) begin
                            alu_a        <= in_data;
                            result_valid <= 1'b0;
                            st           <= S_GOT_A;
                        end
                    end
                    S_ERR: begin
                        if (ev) begin
                            alu_a        <= in_data;
                            err          <= 1'b0;
                            result_valid <= 1'b0;
                            st           <= S_GOT_A;
                        end
                    end
                    default: st <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer: directed vector bench for calc_op_sequencer.
// Timeout checks depend on CALC_SEQ_TIMEOUT_EN.
module tb_calc_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_strobe = 1'b0;
    logic        in_clear = 1'b0;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic        alu_err = 1'b0;
    logic [15:0] alu_result = 16'h0000;
    logic [15:0] result;
    logic        result_valid;
    logic        err;
    logic        busy;
    logic [2:0]  state;

    calc_op_sequencer #(.WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_data(in_data), .in_strobe(in_strobe), .in_clear(in_clear),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_start(alu_start), .alu_done(alu_done), .alu_err(alu_err),
        .alu_result(alu_result), .result(result),
        .result_valid(result_valid), .err(err), .busy(busy),
        .state(state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    // ALU model knobs: dly=0 means never answer
    int          alu_dly = 4;
    logic [15:0] alu_res_v = 16'h0000;
    logic        alu_err_v = 1'b0;
    int          pend = 0;

    always begin
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        if (alu_start) begin
            pend = alu_dly;
        end else if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                alu_done   = 1'b1;
                alu_result = alu_res_v;
                alu_err    = alu_err_v;
            end
        end
    end

    int busy_tot = 0;
    int start_tot = 0;
    always @(negedge clk) begin
        if (busy) busy_tot++;
        if (alu_start) start_tot++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] v);
        in_data = v;
        in_strobe = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        in_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        in_clear = 1'b1;
        @(posedge clk);
        #1;
        in_clear = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({nm, " done_in_time"}, {31'd0, ok}, 32'd1);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  op;
        int          dly;
        logic [15:0] ares;
        logic        aerr;
        logic [2:0]  e_state;
        logic [15:0] e_res;
        logic        e_valid;
        logic        e_err;
        int          e_starts;
        int          e_busy;
    } vec_t;

    vec_t vt[8];

    initial begin
        int b0;
        int s0;
        bit hit;
        vt[0] = '{8'h07, 8'h05, 8'h02, 4, 16'h0023, 1'b0, 3'd5, 16'h0023, 1'b1, 1'b0, 1, 5};
        vt[1] = '{8'h09, 8'h00, 8'h03, 4, 16'h1234, 1'b0, 3'd6, 16'h0000, 1'b0, 1'b1, 0, 0};
        vt[2] = '{8'h0C, 8'h00, 8'hFC, 4, 16'h1234, 1'b0, 3'd6, 16'h0000, 1'b0, 1'b1, 0, 0};
        vt[3] = '{8'h10, 8'h00, 8'h00, 1, 16'h0010, 1'b0, 3'd5, 16'h0010, 1'b1, 1'b0, 1, 2};
        vt[4] = '{8'h64, 8'h07, 8'h03, 6, 16'h000E, 1'b0, 3'd5, 16'h000E, 1'b1, 1'b0, 1, 7};
        vt[5] = '{8'h20, 8'h30, 8'h01, 2, 16'hFFF0, 1'b1, 3'd6, 16'hFFF0, 1'b1, 1'b1, 1, 3};
        vt[6] = '{8'hF0, 8'h0F, 8'h07, 3, 16'h00FF, 1'b0, 3'd5, 16'h00FF, 1'b1, 1'b0, 1, 4};
        vt[7] = '{8'hFF, 8'hFF, 8'hFA, 4, 16'hFE01, 1'b0, 3'd5, 16'hFE01, 1'b1, 1'b0, 1, 5};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst state", {29'd0, state}, 32'd0);
        chk("rst result", {16'd0, result}, 32'd0);
        chk("rst flags", {28'd0, result_valid, err, busy, alu_start}, 32'd0);
        chk("rst regs", {13'd0, alu_op, alu_b, alu_a}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // table-driven calculations
        for (int i = 0; i < 8; i++) begin
            do_clear();
            chk($sformatf("v%0d clr state", i), {29'd0, state}, 32'd0);
            alu_dly   = vt[i].dly;
            alu_res_v = vt[i].ares;
            alu_err_v = vt[i].aerr;
            b0 = busy_tot;
            s0 = start_tot;
            strobe(vt[i].a);
            strobe(vt[i].b);
            strobe(vt[i].op);
            wait_idle($sformatf("v%0d", i));
            chk($sformatf("v%0d state", i), {29'd0, state}, {29'd0, vt[i].e_state});
            chk($sformatf("v%0d result", i), {16'd0, result}, {16'd0, vt[i].e_res});
            chk($sformatf("v%0d valid", i), {31'd0, result_valid}, {31'd0, vt[i].e_valid});
            chk($sformatf("v%0d err", i), {31'd0, err}, {31'd0, vt[i].e_err});
            chk($sformatf("v%0d starts", i), start_tot - s0, vt[i].e_starts);
            chk($sformatf("v%0d busy", i), busy_tot - b0, vt[i].e_busy);
            chk($sformatf("v%0d alu_a", i), {24'd0, alu_a}, {24'd0, vt[i].a});
            chk($sformatf("v%0d alu_b", i), {24'd0, alu_b}, {24'd0, vt[i].b});
            chk($sformatf("v%0d alu_op", i), {29'd0, alu_op}, {29'd0, vt[i].op[2:0]});
        end

        // divide by zero, then a new A restarts from ERR
        do_clear();
        strobe(8'h09);
        strobe(8'h00);
        strobe(8'h03);
        chk("dz state", {29'd0, state}, 32'd6);
        strobe(8'h04);
        chk("dz next state", {29'd0, state}, 32'd1);
        chk("dz next err", {31'd0, err}, 32'd0);
        chk("dz next a", {24'd0, alu_a}, 32'h04);

        // held strobe gives exactly one event
        do_clear();
        in_data = 8'h11;
        in_strobe = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("hold state", {29'd0, state}, 32'd1);
        chk("hold a", {24'd0, alu_a}, 32'h11);
        in_strobe = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("hold after", {29'd0, state}, 32'd1);

        // strobe during WAIT dropped, then SHOW accepts a new A
        do_clear();
        alu_dly = 20;
        alu_res_v = 16'h0003;
        alu_err_v = 1'b0;
        strobe(8'h01);
        strobe(8'h02);
        strobe(8'h00);
        chk("drop in wait", {29'd0, state}, 32'd4);
        strobe(8'h55);
        wait_idle("drop");
        chk("drop state", {29'd0, state}, 32'd5);
        chk("drop a", {24'd0, alu_a}, 32'h01);
        chk("drop result", {16'd0, result}, 32'h0003);
        strobe(8'h08);
        chk("show next state", {29'd0, state}, 32'd1);
        chk("show next valid", {31'd0, result_valid}, 32'd0);
        chk("show next a", {24'd0, alu_a}, 32'h08);

        // ena low: new events ignored, in-flight op completes
        do_clear();
        ena = 1'b0;
        strobe(8'h33);
        chk("ena low state", {29'd0, state}, 32'd0);
        chk("ena low a", {24'd0, alu_a}, 32'h00);
        ena = 1'b1;
        alu_dly = 10;
        alu_res_v = 16'h0077;
        strobe(8'h03);
        strobe(8'h04);
        strobe(8'h05);
        ena = 1'b0;
        wait_idle("ena wait");
        chk("ena wait state", {29'd0, state}, 32'd5);
        chk("ena wait result", {16'd0, result}, 32'h0077);
        ena = 1'b1;

        // clear coincident with alu_done
        do_clear();
        alu_dly = 6;
        alu_res_v = 16'h0042;
        strobe(8'h02);
        strobe(8'h21);
        strobe(8'h02);
        hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #2;
            if (alu_done) begin
                in_clear = 1'b1;
                hit = 1'b1;
                break;
            end
        end
        chk("clr+done seen", {31'd0, hit}, 32'd1);
        @(posedge clk);
        #1;
        in_clear = 1'b0;
        chk("clr+done state", {29'd0, state}, 32'd0);
        chk("clr+done result", {16'd0, result}, 32'd0);
        chk("clr+done valid", {31'd0, result_valid}, 32'd0);

        // async reset mid-WAIT; late alu_done ignored afterwards
        do_clear();
        alu_dly = 30;
        alu_res_v = 16'h00AB;
        strobe(8'h07);
        strobe(8'h05);
        strobe(8'h02);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst state", {29'd0, state}, 32'd0);
        chk("arst flags", {28'd0, result_valid, err, busy, alu_start}, 32'd0);
        chk("arst regs", {13'd0, alu_op, alu_b, alu_a}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (35) @(posedge clk);
        #1;
        chk("late done state", {29'd0, state}, 32'd0);
        chk("late done result", {16'd0, result}, 32'd0);
        chk("late done valid", {31'd0, result_valid}, 32'd0);

        // ALU never answers
        do_clear();
        alu_dly = 0;
        b0 = busy_tot;
        strobe(8'h06);
        strobe(8'h02);
        strobe(8'h00);
`ifdef CALC_SEQ_TIMEOUT_EN
        wait_idle("tmo");
        chk("tmo state", {29'd0, state}, 32'd6);
        chk("tmo err", {31'd0, err}, 32'd1);
        chk("tmo result", {16'd0, result}, 32'hFFFF);
        chk("tmo valid", {31'd0, result_valid}, 32'd0);
        chk("tmo busy", busy_tot - b0, 32'd17);
`else
        repeat (40) @(posedge clk);
        #1;
        chk("no tmo state", {29'd0, state}, 32'd4);
        chk("no tmo busy", {31'd0, busy}, 32'd1);
        chk("no tmo err", {31'd0, err}, 32'd0);
        do_clear();
        chk("no tmo clr", {29'd0, state}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
